// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state type for the bus-arbitration slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Number of beats in a burst; 0 means undefined length (INCR).
  function automatic logic [4:0] burst_beats(hburst_t b);
    logic [4:0] n;
    n = 5'd1;
    case (b)
      SINGLE:         n = 5'd1;
      INCR:           n = 5'd0;
      WRAP4, INCR4:   n = 5'd4;
      WRAP8, INCR8:   n = 5'd8;
      WRAP16, INCR16: n = 5'd16;
      default:        n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after ptr wins, ptr itself last.
module ahb_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: grant is registered one cycle ahead of address-phase
// ownership (HMASTER) and is held across fixed-length bursts and locked sequences.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_MASTER = MW'(DEFAULT_MASTER);

  arb_state_t             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          master_q, master_d;
  logic                   mastlock_q, mastlock_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [MW-1:0]          pick_idx;
  logic                   pick_found;

  htrans_t                trans;
  hburst_t                burst;
  logic [4:0]             beats;
  logic                   owner_lock;
  logic                   is_nonseq;
  logic                   is_seq;
  logic                   is_idle;
  logic                   fixed_burst;
  logic                   lock_pending;
  logic                   rearb;
  logic [MW-1:0]          grant_idx;

  ahb_rr_picker #(
    .N (NUM_MASTERS),
    .W (MW)
  ) u_picker (
    .req   (HBUSREQ),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign trans       = htrans_t'(HTRANS);
  assign burst       = hburst_t'(HBURST);
  assign beats       = burst_beats(burst);
  assign owner_lock  = HLOCK[master_q];
  assign is_nonseq   = (trans == NONSEQ);
  assign is_seq      = (trans == SEQ);
  assign is_idle     = (trans == IDLE);
  assign fixed_burst = (beats >= 5'd4);

  // Lock requests take effect on the NONSEQ that starts them; once locked,
  // only dropping HLOCK of the owner releases it.
  assign lock_pending = (state_q == LOCKED) ? owner_lock : (owner_lock && is_nonseq);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) grant_idx = MW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    rearb      = 1'b0;

    if (HREADY) begin
      master_d   = grant_idx;
      mastlock_d = lock_pending;

      case (state_q)
        ARB: begin
          if (owner_lock && is_nonseq) begin
            state_d           = LOCKED;
            grant_d           = '0;
            grant_d[master_q] = 1'b1;
          end else if (is_nonseq && fixed_burst) begin
            state_d = BURST;
            cnt_d   = 4'(beats - 5'd1);
          end else begin
            rearb = 1'b1;
          end
        end
        BURST: begin
          if (owner_lock && is_nonseq) begin
            state_d           = LOCKED;
            cnt_d             = '0;
            grant_d           = '0;
            grant_d[master_q] = 1'b1;
          end else if (is_idle || is_nonseq) begin
            state_d = ARB;
            cnt_d   = '0;
            rearb   = 1'b1;
          end else if (is_seq) begin
            if (cnt_q == 4'd1) begin
              // Last beat accepted: the next owner is chosen on this same edge.
              state_d = ARB;
              cnt_d   = '0;
              rearb   = 1'b1;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        LOCKED: begin
          if (!owner_lock) begin
            state_d = ARB;
            rearb   = 1'b1;
          end
        end
        default: begin
          state_d = ARB;
          cnt_d   = '0;
        end
      endcase

      if (rearb) begin
        if (pick_found) begin
          grant_d  = pick_grant;
          rr_ptr_d = pick_idx;
        end else begin
          grant_d = DEF_GRANT;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ARB;
      cnt_q      <= '0;
      rr_ptr_q   <= DEF_MASTER;
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_MASTER;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      assert ($onehot(grant_q)) else $error("HGRANT is not one-hot: %b", grant_q);
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule
